// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: default widths, jump opcodes,
// status bit positions and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int OP_W_DEF  = 7;
  localparam int LIT_W_DEF = 8;

  localparam logic [OP_W_DEF-1:0] OP_JMP = 7'h53;
  localparam logic [OP_W_DEF-1:0] OP_JEQ = 7'h54;
  localparam logic [OP_W_DEF-1:0] OP_JNE = 7'h55;
  localparam logic [OP_W_DEF-1:0] OP_JGT = 7'h56;
  localparam logic [OP_W_DEF-1:0] OP_JLT = 7'h57;
  localparam logic [OP_W_DEF-1:0] OP_JGE = 7'h58;
  localparam logic [OP_W_DEF-1:0] OP_JLE = 7'h59;
  localparam logic [OP_W_DEF-1:0] OP_JCR = 7'h5A;
  localparam logic [OP_W_DEF-1:0] OP_JOV = 7'h5B;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundles the instruction-memory handshake and the decoder-facing signals
// of the fetch sequencer; master is the sequencer, slave is its environment.
interface pc_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int OP_W  = 7,
  parameter int LIT_W = 8
);
  logic                  imem_req;
  logic [PC_W-1:0]       imem_addr;
  logic                  imem_valid;
  logic [OP_W+LIT_W-1:0] imem_data;
  logic [OP_W-1:0]       opcode;
  logic [LIT_W-1:0]      literal;
  logic                  exec_valid;
  logic                  flag_we;
  logic [3:0]            alu_flags;
  logic [3:0]            status;
  logic                  jump_taken;

  modport master (
    output imem_req, imem_addr, opcode, literal, exec_valid, status, jump_taken,
    input  imem_valid, imem_data, flag_we, alu_flags
  );

  modport slave (
    input  imem_req, imem_addr, opcode, literal, exec_valid, status, jump_taken,
    output imem_valid, imem_data, flag_we, alu_flags
  );
endinterface

// File: rtl/jump_cond.sv
// Combinational branch resolver: decides whether an opcode is a taken jump
// given the stored {V,C,N,Z} flags. Non-jump opcodes are never taken.
module jump_cond
  import cpu_pkg::*;
(
  input  logic [OP_W_DEF-1:0] i_opcode,
  input  logic [3:0]          i_status,
  output logic                o_taken
);
  logic w_z, w_n, w_c, w_v;

  assign w_z = i_status[ST_Z];
  assign w_n = i_status[ST_N];
  assign w_c = i_status[ST_C];
  assign w_v = i_status[ST_V];

  always_comb begin
    o_taken = 1'b0;
    case (i_opcode)
      OP_JMP:  o_taken = 1'b1;
      OP_JEQ:  o_taken = w_z;
      OP_JNE:  o_taken = ~w_z;
      OP_JGT:  o_taken = ~w_n & ~w_z;
      OP_JLT:  o_taken = w_n;
      OP_JGE:  o_taken = ~w_n;
      OP_JLE:  o_taken = w_n | w_z;
      OP_JCR:  o_taken = w_c;
      OP_JOV:  o_taken = w_v;
      default: o_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch/sequencing unit: owns PC, IR and status flags, fetches
// over a req/valid handshake and resolves jumps in the execute cycle.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int LIT_W = LIT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  pc_sequencer_if.master bus
);
  seq_state_e            r_state;
  logic [PC_W-1:0]       r_pc;
  logic [OP_W+LIT_W-1:0] r_ir;
  logic [3:0]            r_status;
  logic                  r_req;
  logic                  r_exec;
  logic                  r_jump_taken;

  logic [OP_W-1:0]       w_opcode;
  logic [LIT_W-1:0]      w_literal;
  logic                  w_taken;

  assign w_opcode  = r_ir[OP_W+LIT_W-1:LIT_W];
  assign w_literal = r_ir[LIT_W-1:0];

  jump_cond u_jump_cond (
    .i_opcode (w_opcode),
    .i_status (r_status),
    .o_taken  (w_taken)
  );

  // The jump decision reads r_status before any flag write in the same
  // execute cycle, so a flag-writing jump branches on the old flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_ir         <= '0;
      r_status     <= '0;
      r_req        <= 1'b0;
      r_exec       <= 1'b0;
      r_jump_taken <= 1'b0;
    end else begin
      r_jump_taken <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.imem_valid) begin
            r_ir    <= bus.imem_data;
            r_req   <= 1'b0;
            r_exec  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_exec <= 1'b0;
          if (bus.flag_we) begin
            r_status <= bus.alu_flags;
          end
          if (w_taken) begin
            r_pc         <= w_literal[PC_W-1:0];
            r_jump_taken <= 1'b1;
          end else begin
            r_pc <= r_pc + PC_W'(1);
          end
          if (en) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_exec  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_pc;
  assign bus.opcode     = w_opcode;
  assign bus.literal    = w_literal;
  assign bus.exec_valid = r_exec;
  assign bus.status     = r_status;
  assign bus.jump_taken = r_jump_taken;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: the bench plays instruction memory and
// ALU, and tracks architectural PC/flags/IR with a small behavioural model.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [7:0]  mPc;
  logic [3:0]  mStatus;
  logic [14:0] mWord;

  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus.master)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural branch rule, straight from the opcode table.
  function automatic bit modelTaken(input logic [6:0] op, input logic [3:0] f);
    bit z, n, c, v;
    z = f[0]; n = f[1]; c = f[2]; v = f[3];
    case (op)
      7'h53:   return 1'b1;
      7'h54:   return z;
      7'h55:   return !z;
      7'h56:   return !n && !z;
      7'h57:   return n;
      7'h58:   return !n;
      7'h59:   return n || z;
      7'h5A:   return c;
      7'h5B:   return v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [14:0] nonJumpWord();
    logic [6:0] op;
    op = 7'($urandom_range(0, 'h52));
    return {op, 8'($urandom_range(0, 255))};
  endfunction

  function automatic logic [14:0] randomWord();
    logic [6:0] op;
    if ($urandom_range(0, 1) == 0) op = 7'($urandom_range('h53, 'h5B));
    else                           op = 7'($urandom_range(0, 127));
    return {op, 8'($urandom_range(0, 255))};
  endfunction

  task automatic scrambleIgnored;
    bus.flag_we   = 1'($urandom_range(0, 1));
    bus.alu_flags = 4'($urandom_range(0, 15));
    bus.imem_data = 15'($urandom);
  endtask

  // One full fetch/execute of `word`, memory answering after `delay` cycles.
  task automatic applyStimulus(input logic [14:0] word, input int delay, input bit flagWe,
                               input logic [3:0] flags, input bit dropEn);
    int  waited;
    bit  taken;
    waited = 0;
    while (bus.imem_req !== 1'b1 && waited < 8) begin
      scrambleIgnored();
      tick();
      waited++;
    end
    checkOutput("reqSeen", 32'(bus.imem_req), 32'(1));
    checkOutput("fetchAddr", 32'(bus.imem_addr), 32'(mPc));
    if (dropEn) en = 1'b0;
    for (int d = 0; d < delay; d++) begin
      bus.imem_valid = 1'b0;
      scrambleIgnored();
      tick();
      checkOutput("reqHeld", 32'(bus.imem_req), 32'(1));
      checkOutput("addrStable", 32'(bus.imem_addr), 32'(mPc));
      checkOutput("opcodeHold", 32'(bus.opcode), 32'(mWord[14:8]));
      checkOutput("jumpPulseLen", 32'(bus.jump_taken), 32'(0));
    end
    bus.imem_valid = 1'b1;
    bus.imem_data  = word;
    bus.flag_we    = 1'($urandom_range(0, 1));
    bus.alu_flags  = 4'($urandom_range(0, 15));
    tick();
    checkOutput("execValid", 32'(bus.exec_valid), 32'(1));
    checkOutput("opcode", 32'(bus.opcode), 32'(word[14:8]));
    checkOutput("literal", 32'(bus.literal), 32'(word[7:0]));
    checkOutput("reqInExec", 32'(bus.imem_req), 32'(0));
    checkOutput("jumpPulseLen", 32'(bus.jump_taken), 32'(0));
    bus.imem_valid = 1'($urandom_range(0, 1));
    bus.imem_data  = 15'($urandom);
    bus.flag_we    = flagWe;
    bus.alu_flags  = flags;
    taken = modelTaken(word[14:8], mStatus);
    if (flagWe) mStatus = flags;
    mPc   = taken ? word[7:0] : mPc + 8'd1;
    mWord = word;
    tick();
    bus.imem_valid = 1'b0;
    bus.flag_we    = 1'b0;
    checkOutput("execDone", 32'(bus.exec_valid), 32'(0));
    checkOutput("jumpTaken", 32'(bus.jump_taken), 32'(taken));
    checkOutput("status", 32'(bus.status), 32'(mStatus));
    checkOutput("reqAfterExec", 32'(bus.imem_req), 32'(!dropEn));
    checkOutput("nextAddr", 32'(bus.imem_addr), 32'(mPc));
    if (dropEn) begin
      for (int k = 0; k < 3; k++) begin
        scrambleIgnored();
        tick();
        checkOutput("idleReq", 32'(bus.imem_req), 32'(0));
        checkOutput("idleExec", 32'(bus.exec_valid), 32'(0));
        checkOutput("idleStatus", 32'(bus.status), 32'(mStatus));
      end
    end
  endtask

  task automatic resume;
    en = 1'b1;
    tick();
    checkOutput("resumeReq", 32'(bus.imem_req), 32'(1));
    checkOutput("resumeAddr", 32'(bus.imem_addr), 32'(mPc));
  endtask

  initial begin
    rst            = 1'b1;
    en             = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    bus.flag_we    = 1'b0;
    bus.alu_flags  = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rstReq", 32'(bus.imem_req), 32'(0));
    checkOutput("rstAddr", 32'(bus.imem_addr), 32'(0));
    checkOutput("rstExec", 32'(bus.exec_valid), 32'(0));
    checkOutput("rstJump", 32'(bus.jump_taken), 32'(0));
    checkOutput("rstOpcode", 32'(bus.opcode), 32'(0));
    checkOutput("rstLiteral", 32'(bus.literal), 32'(0));
    checkOutput("rstStatus", 32'(bus.status), 32'(0));
    tick();
    checkOutput("enLowReq", 32'(bus.imem_req), 32'(0));
    mPc = 8'd0; mStatus = 4'd0; mWord = 15'd0;

    resume();
    for (int i = 0; i < 3; i++) applyStimulus(nonJumpWord(), 0, 1'b0, 4'd0, 1'b0);
    applyStimulus({7'h53, 8'h10}, 0, 1'b0, 4'd0, 1'b0);
    checkOutput("jmpTarget", 32'(bus.imem_addr), 32'('h10));

    applyStimulus(nonJumpWord(), 0, 1'b1, 4'b0001, 1'b0);
    applyStimulus({7'h54, 8'h20}, 0, 1'b0, 4'd0, 1'b0);
    applyStimulus(nonJumpWord(), 1, 1'b1, 4'b0000, 1'b0);
    applyStimulus({7'h54, 8'h20}, 0, 1'b0, 4'd0, 1'b0);
    applyStimulus(nonJumpWord(), 0, 1'b1, 4'b0001, 1'b0);
    applyStimulus({7'h55, 8'h40}, 0, 1'b1, 4'b0000, 1'b0);
    applyStimulus({7'h55, 8'h40}, 2, 1'b0, 4'd0, 1'b0);

    applyStimulus({7'h53, 8'hFF}, 0, 1'b0, 4'd0, 1'b0);
    applyStimulus(nonJumpWord(), 0, 1'b1, 4'b1010, 1'b0);
    checkOutput("pcWrap", 32'(bus.imem_addr), 32'(0));

    // Memory stalls, then reset lands mid-fetch and a late valid follows.
    bus.imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    mPc = 8'd0; mStatus = 4'd0; mWord = 15'd0;
    checkOutput("midRstReq", 32'(bus.imem_req), 32'(0));
    checkOutput("midRstAddr", 32'(bus.imem_addr), 32'(0));
    checkOutput("midRstStatus", 32'(bus.status), 32'(0));
    bus.imem_valid = 1'b1;
    bus.imem_data  = {7'h53, 8'h77};
    tick();
    bus.imem_valid = 1'b0;
    checkOutput("lateValidExec", 32'(bus.exec_valid), 32'(0));
    checkOutput("lateValidReq", 32'(bus.imem_req), 32'(0));
    checkOutput("lateValidOpcode", 32'(bus.opcode), 32'(0));
    resume();

    applyStimulus(nonJumpWord(), 2, 1'b0, 4'd0, 1'b1);
    resume();

    for (int i = 0; i < 80; i++) begin
      bit drop;
      drop = ($urandom_range(0, 9) == 0);
      applyStimulus(randomWord(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), drop);
      if (drop) resume();
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction fetch and sequencing unit for the accumulator CPU. It owns the program counter and the 4-bit status (flags) register. It fetches each instruction word from instruction memory with a request/valid handshake and presents the 7-bit opcode plus 8-bit literal to the control decoder. It also resolves the JMP/Jcc opcodes against the stored flags. Together with the control decoder, it closes the fetch → decode → execute loop.

## Interface
Parameters:
- PC_W, 8, program counter and instruction-memory address width
- OP_W, 7, opcode width
- LIT_W, 8, literal / jump-target width (PC_W ≤ LIT_W; jump target = literal[PC_W-1:0])

Ports:
- clk  in  1  single system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; when low, no new fetch is started
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_valid  in  1  instruction word valid this cycle
- imem_data  in  OP_W+LIT_W  instruction word {opcode, literal}
- opcode  out  OP_W  current opcode to control decoder
- literal  out  LIT_W  current literal (K / DIR)
- exec_valid  out  1  execute cycle; the top level qualifies LA/LB/mem_we with it
- flag_we  in  1  latch alu_flags this execute cycle
- alu_flags  in  4  {V,C,N,Z} from ALU
- status  out  4  stored flags to control decoder: [0]=Z, [1]=N, [2]=C, [3]=V
- jump_taken  out  1  registered; high for the cycle after an execute that loaded the PC from literal

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE → FETCH when en=1.
- FETCH: imem_req=1, imem_addr=PC.
  - On imem_valid=1: capture imem_data into IR, go to EXEC.
  - Otherwise hold.
- EXEC: exec_valid=1, opcode/literal come from IR.
  - PC update at the end of the cycle:
    - taken jump → PC = literal[PC_W-1:0]
    - otherwise → PC = PC+1, modulo 2^PC_W (all-ones wraps to 0)
  - Next state: FETCH if en=1, else IDLE.
- Jump opcodes and conditions (all other opcodes are not jumps):
  - 0x53 JMP: always
  - 0x54 JEQ: Z
  - 0x55 JNE: !Z
  - 0x56 JGT: !N & !Z
  - 0x57 JLT: N
  - 0x58 JGE: !N
  - 0x59 JLE: N | Z
  - 0x5A JCR: C
  - 0x5B JOV: V
- Flags:
  - status ← alu_flags only when flag_we=1 during EXEC; flag_we outside EXEC is ignored.
  - The jump condition uses status before any same-cycle update (flag_we together with a jump opcode: flags update, jump decision uses old flags).
- en:
  - en dropping during FETCH does not abort an outstanding request; the fetch completes and the instruction executes.
  - After that execute, the unit parks in IDLE.
- imem_valid is ignored outside FETCH.
- Reset values: PC=0, state=IDLE, IR=0 (opcode=0, literal=0), status=0, imem_req=0, exec_valid=0, jump_taken=0, imem_addr=0.
- Reset mid-fetch or mid-execute: the request is dropped, the in-flight instruction does not execute, and a valid arriving after reset is ignored.

## Timing
- opcode, literal, status, imem_req, exec_valid and jump_taken are all registered; no combinational input→output path.
- imem_addr is stable for as long as imem_req is high.
- Minimum rate is one instruction per 2 cycles: FETCH with same-cycle imem_valid, then EXEC.
- Each cycle imem_valid is delayed adds one cycle.
- opcode/literal stay constant from IR capture until the next capture.
- First imem_req is asserted in the cycle after IDLE sees en=1.

## Structure
- Shared package cpu_pkg:
  - OP_W/LIT_W defaults
  - jump opcode constants (OP_JMP … OP_JOV)
  - status bit indices (ST_Z, ST_N, ST_C, ST_V)
  - state encoding
- One sub-module: jump_cond, combinational (opcode, status) → taken. Reused later by the CMP/branch verification model.
- Estimated ~150–250 lines total.

## Test plan
- Reset then en=1, memory returns words with valid same cycle → imem_addr 0,1,2…; exec_valid every 2nd cycle; opcodes presented in order.
- Address 3 holds JMP 0x10 (imem_data = {7'h53, 8'h10}) → next imem_addr = 0x10; jump_taken=1 for one cycle.
- Flags:
  - flag_we with alu_flags=4'b0001, then JEQ 0x20 → taken.
  - Same sequence with Z=0 → not taken, PC+1.
  - flag_we asserted together with the JNE → old flags are used for the decision.
- imem_valid delayed 3 cycles, then rst asserted during the wait → imem_req drops, PC=0, IDLE; a late valid has no effect.
- PC=0xFF, non-jump instruction → next imem_addr = 0x00.
- en deasserted during FETCH → that instruction executes, then IDLE with imem_req=0; re-asserting en resumes at PC+1.
